uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  UART transmitter: serialises one DATA_WIDTH word per valid/ready handshake, LSB first.
//  Frame: start(0), data, optional parity, 1 or 2 stop(1); line idles high.
//  Transmit-side peer of the UART receive path; frame format parameters match it.
// PARAMETERS
//  MAX_WIDTH      32                 width of baud_rate_i (clocks per bit)
//  NUM_STOP_BITS  1                  1 or 2; any other value is an elaboration-time error
//  PARITY_MODE    uart_pkg::PAR_NONE PAR_NONE / PAR_EVEN / PAR_ODD (type uart_pkg::parity_e)
//  DATA_WIDTH     8                  data bits per frame
// PORTS
//  clk_i        in   1           clock
//  rst_i        in   1           reset, synchronous, active-high
//  baud_rate_i  in   MAX_WIDTH   clocks per bit; sampled at accept; 0 treated as 1
//  data_i       in   DATA_WIDTH  word to send; sampled when valid_i && ready_o
//  valid_i      in   1           word offered
//  ready_o      out  1           block can accept a word this cycle
//  tx_o         out  1           serial line, registered, idle high
//  busy_o       out  1           frame in progress (state != IDLE)
//  tx_done_o    out  1           1-cycle pulse in the last clock of the final stop bit
// BEHAVIOUR
//  Reset values: tx_o=1, ready_o=1, busy_o=0, tx_done_o=0, state=IDLE, counters=0, buffers empty.
//  Reset mid-frame: tx_o=1 and state=IDLE on the next clock; the in-flight word and any buffered word are dropped.
//  FSM (uart_pkg::tx_state_t): IDLE -> START_BIT -> DATA_BITS -> [PARITY_BIT] -> [STOP_BITS2] -> STOP_BITS1 -> IDLE.
//  Baud counter: cleared on accept and on every tick; tick when cnt == max(baud_rate_i_latched,1)-1.
//  Each non-IDLE state lasts exactly one tick period.
//  Accept (valid_i && ready_o) in cycle N:
//   - Latch data into the shift reg and baud_rate_i into the baud reg.
//   - tx_o=0 from cycle N+1 (START_BIT).
//  DATA_BITS:
//   - tx_o = shift[0]; shift right on each tick.
//   - Bit counter 0..DATA_WIDTH-1; leave the state on tick when count == DATA_WIDTH-1.
//  PARITY_BIT: EVEN -> tx_o = ^data; ODD -> tx_o = ~^data. Skipped when PAR_NONE.
//  STOP_BITS2 is present only when NUM_STOP_BITS==2. tx_o=1 in both stop states.
//  tx_done_o = (state==STOP_BITS1) && tick.
//  Frame length = (1+DATA_WIDTH+P+NUM_STOP_BITS)*max(baud,1) clocks, where P = (PARITY_MODE!=PAR_NONE).
//  Without buffer, ready_o = (state==IDLE). Back-to-back frames then have a 1-clock idle-high gap.
//  Changes on data_i/baud_rate_i after accept have no effect on the current frame.
// CONFIGURATION
//  UART_TX_HOLD_BUF_EN defined: adds a one-entry holding register (data + baud).
//   - ready_o = !hold_full; accept is legal in any state.
//   - On the STOP_BITS1 tick with hold_full: go straight to START_BIT (zero gap), pop hold, tx_done_o still pulses.
//   - Accept in IDLE with hold empty: behaves as in the unbuffered case (bypass).
//   - Accept on the same cycle as a pop: the new word lands in hold.
//  UART_TX_HOLD_BUF_EN undefined: no holding register; behaviour as in BEHAVIOUR.
// STRUCTURE
//  uart_pkg (shared with the receiver): parity_e {PAR_NONE, PAR_EVEN, PAR_ODD}; tx_state_t enum (3 bits); default constants.
//  Sub-module uart_baud_gen: clear input, max input, tick output; reusable by the receiver.
//  uart_tx keeps the FSM, shift reg, bit counter, parity and the optional holding register.
// TESTING
//  1 baud=4, PAR_NONE, 1 stop, data=0xA5, accept @0:
//    tx_o = 0,1,0,1,0,0,1,0,1,1 (4 clk each, from clk 1); tx_done_o @clk 40; ready_o=1 @41.
//  2 PAR_EVEN, data=0x07: parity bit=1.
//    PAR_ODD, data=0x07: parity bit=0.
//    PAR_EVEN, data=0x00: parity bit=0.
//  3 NUM_STOP_BITS=2, baud=3, data=0xFF: frame=33 clk; tx_o high for last 6 clk; one done pulse.
//  4 baud=0 and baud=1, data=0x3C: one clock per bit; frame=10 clk; identical waveforms.
//  5 Assert rst_i mid DATA_BITS:
//    next clk tx_o=1, busy_o=0, ready_o=1.
//    A new accept then sends a clean frame.
//  6 With UART_TX_HOLD_BUF_EN, baud=2, send 0x55 then 0xAA back-to-back:
//    second start bit immediately follows stop (no gap); ready_o=0 while hold is full.
//    Without the macro: exactly 1 idle clk between frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding,
// default frame constants and a parity helper. Used by the transmitter
// and the receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BITS2 = 3'd4,
        STOP_BITS1 = 3'd5
    } tx_state_t;

    localparam int unsigned DEFAULT_MAX_WIDTH     = 32;
    localparam int unsigned DEFAULT_DATA_WIDTH    = 8;
    localparam int unsigned DEFAULT_NUM_STOP_BITS = 1;

    // Parity bit from the XOR-reduction of the data word.
    function automatic logic parity_bit(input logic data_xor, input parity_e mode);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts clocks and raises tick_o in the last clock of
// every bit period. A max_i of 0 behaves like 1 (one clock per bit).
// clr_i holds the count at zero so a new frame starts on a full period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned MAX_WIDTH = DEFAULT_MAX_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic [MAX_WIDTH-1:0] max_i,
    output logic                 tick_o
);

    logic [MAX_WIDTH-1:0] cnt_q;
    logic [MAX_WIDTH-1:0] limit;

    // Effective period length, never zero.
    always_comb begin
        limit = (max_i == '0) ? MAX_WIDTH'(1) : max_i;
    end

    assign tick_o = (cnt_q == (limit - MAX_WIDTH'(1)));

    // Period counter, restarts on clear and on every tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + MAX_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, LSB first,
// frame = start, data, optional parity, 1 or 2 stop bits; line idles high.
// Optional build macro UART_TX_HOLD_BUF_EN adds a one-entry holding
// register so a second word can queue behind the frame in flight and
// follow it with no idle gap.
//
// state      | meaning
// -----------+---------------------------------------------
// IDLE       | line high, waiting for a word
// START_BIT  | driving the start bit (0)
// DATA_BITS  | shifting data out LSB first
// PARITY_BIT | driving the parity bit (parity builds only)
// STOP_BITS2 | first of two stop bits (2-stop builds only)
// STOP_BITS1 | final stop bit; done pulses on its last clock
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned MAX_WIDTH     = DEFAULT_MAX_WIDTH,
    parameter int unsigned NUM_STOP_BITS = DEFAULT_NUM_STOP_BITS,
    parameter parity_e     PARITY_MODE   = PAR_NONE,
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [MAX_WIDTH-1:0]  baud_rate_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  tx_done_o
);

    generate
        if ((NUM_STOP_BITS != 1) && (NUM_STOP_BITS != 2)) begin : g_bad_stop_bits
            $error("uart_tx: NUM_STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam bit                    HAS_PARITY = (PARITY_MODE != PAR_NONE);
    localparam int unsigned           BIT_CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT   = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam tx_state_t             FIRST_STOP = (NUM_STOP_BITS == 2) ? STOP_BITS2 : STOP_BITS1;
    localparam tx_state_t             AFTER_DATA = HAS_PARITY ? PARITY_BIT : FIRST_STOP;

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  par_q, par_d;
    logic [MAX_WIDTH-1:0]  baud_q, baud_d;
    logic                  tx_q, tx_d;

    logic                  tick;
    logic                  idle;
    logic                  frame_end;
    logic                  accept;
    logic                  start_frame;
    logic [DATA_WIDTH-1:0] src_data;
    logic [MAX_WIDTH-1:0]  src_baud;

    assign idle      = (state_q == IDLE);
    assign frame_end = (state_q == STOP_BITS1) && tick;

`ifdef UART_TX_HOLD_BUF_EN
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic [MAX_WIDTH-1:0]  hold_baud_q;
    logic                  direct;
    logic                  pop;
    logic                  push;

    // A word accepted with the hold empty starts straight away when the
    // line is free (idle, or the final stop clock); otherwise it waits in hold.
    assign ready_o     = ~hold_full_q;
    assign accept      = valid_i & ready_o;
    assign direct      = accept & (idle | frame_end);
    assign pop         = hold_full_q & (idle | frame_end);
    assign push        = accept & ~direct;
    assign start_frame = direct | pop;
    assign src_data    = pop ? hold_data_q : data_i;
    assign src_baud    = pop ? hold_baud_q : baud_rate_i;
    assign hold_full_d = (hold_full_q & ~pop) | push;

    // Holding register for the queued word and its bit period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            hold_baud_q <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            if (push) begin
                hold_data_q <= data_i;
                hold_baud_q <= baud_rate_i;
            end
        end
    end
`else
    assign ready_o     = idle;
    assign accept      = valid_i & ready_o;
    assign start_frame = accept;
    assign src_data    = data_i;
    assign src_baud    = baud_rate_i;
`endif

    uart_baud_gen #(
        .MAX_WIDTH (MAX_WIDTH)
    ) u_baud_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (idle),
        .max_i  (baud_q),
        .tick_o (tick)
    );

    // Next-state logic; every non-idle state lasts one bit period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start_frame) state_d = START_BIT;
            START_BIT:  if (tick) state_d = DATA_BITS;
            DATA_BITS:  if (tick && (bit_cnt_q == LAST_BIT)) state_d = AFTER_DATA;
            PARITY_BIT: if (tick) state_d = FIRST_STOP;
            STOP_BITS2: if (tick) state_d = STOP_BITS1;
            STOP_BITS1: if (tick) state_d = start_frame ? START_BIT : IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath next values; tx is computed from the next state so the
    // registered line changes in the same clock as the state.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        baud_d    = baud_q;
        if (start_frame) begin
            shift_d   = src_data;
            bit_cnt_d = '0;
            par_d     = parity_bit(^src_data, PARITY_MODE);
            baud_d    = src_baud;
        end else if ((state_q == DATA_BITS) && tick) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BIT_CNT_W'(1);
        end

        tx_d = 1'b1;
        case (state_d)
            START_BIT:  tx_d = 1'b0;
            DATA_BITS:  tx_d = shift_d[0];
            PARITY_BIT: tx_d = par_d;
            default:    tx_d = 1'b1;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            baud_q    <= baud_d;
            tx_q      <= tx_d;
        end
    end

    assign tx_o      = tx_q;
    assign busy_o    = ~idle;
    assign tx_done_o = frame_end;

endmodule
